// File: rtl/timer_csr.sv
`default_nettype none
// ============================================================================
// Module   : timer_csr
// Purpose  : Register front end for the timer/PWM core: start pulse, PWM
//            shadow/active registers, sticky timeout status, counter and irq.
// Revision : 1.0 - initial release
// ============================================================================
module timer_csr (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        timer_en,
    output logic        pwm_en,
    output logic [31:0] load_tmr0,
    output logic [15:0] load_pwm0,
    output logic [15:0] duty_cycle_pwm0,
    input  logic        timeout_dly,
    input  logic        pwm,
    output logic        irq
);

    localparam logic [2:0] c_reg_ctrl   = 3'd0;
    localparam logic [2:0] c_reg_load   = 3'd1;
    localparam logic [2:0] c_reg_pwm    = 3'd2;
    localparam logic [2:0] c_reg_status = 3'd3;
    localparam logic [2:0] c_reg_count  = 3'd4;

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_start_pls;
    logic        r_te_q;
    logic        r_tmo_s;
    logic        r_tmo_q;
    logic        r_pwm_en;
    logic        r_auto_reload;
    logic        r_irq_en;
    logic [31:0] r_load;
    logic [15:0] r_period_sh;
    logic [15:0] r_duty_sh;
    logic [15:0] r_period;
    logic [15:0] r_duty;
    logic        r_timeout;
    logic        r_busy;
    logic [15:0] r_count;

    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_sel;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_pwm;
    logic        w_wr_status;
    logic        w_wr_count;
    logic        w_edge;
    logic        w_reload;
    logic        w_start;
    logic        w_pwm_commit;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    // Requests arriving during the ack cycle are dropped, capping the rate at one per two cycles.
    assign w_acc       = req & ~r_ack;
    assign w_wr        = w_acc & we;
    assign w_rd        = w_acc & ~we;
    assign w_sel       = addr[4:2];
    assign w_wr_ctrl   = w_wr & (w_sel == c_reg_ctrl);
    assign w_wr_load   = w_wr & (w_sel == c_reg_load);
    assign w_wr_pwm    = w_wr & (w_sel == c_reg_pwm);
    assign w_wr_status = w_wr & (w_sel == c_reg_status);
    assign w_wr_count  = w_wr & (w_sel == c_reg_count);
    assign w_unused    = &{1'b0, addr[1:0]};

    // timeout_dly is sampled first, so the edge is seen one cycle after it rises.
    assign w_edge   = r_tmo_s & ~r_tmo_q;
    assign w_reload = w_edge & r_auto_reload & r_busy & ~r_te_q;

    // A run that ends on this very edge frees the timer for a coincident START.
    assign w_start  = w_wr_ctrl & wdata[0] & ~w_reload &
                      (~r_busy | (w_edge & ~r_auto_reload));

    assign w_pwm_commit = w_wr_ctrl & (wdata[4] | (r_pwm_en & ~wdata[1]));

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            c_reg_ctrl:   w_rd_mux = {28'd0, r_irq_en, r_auto_reload, r_pwm_en, 1'b0};
            c_reg_load:   w_rd_mux = r_load;
            c_reg_pwm:    w_rd_mux = {r_duty_sh, r_period_sh};
            c_reg_status: w_rd_mux = {29'd0, pwm, r_busy, r_timeout};
            c_reg_count:  w_rd_mux = {16'd0, r_count};
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack         <= 1'b0;
            r_rdata       <= '0;
            r_start_pls   <= 1'b0;
            r_te_q        <= 1'b0;
            r_tmo_s       <= 1'b0;
            r_tmo_q       <= 1'b0;
            r_pwm_en      <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_load        <= 32'd1;
            r_period_sh   <= '0;
            r_duty_sh     <= '0;
            r_period      <= '0;
            r_duty        <= '0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_count       <= '0;
        end else begin
            r_ack       <= w_acc;
            r_rdata     <= w_rd ? w_rd_mux : 32'd0;
            r_start_pls <= w_start;
            r_te_q      <= timer_en;
            r_tmo_s     <= timeout_dly;
            r_tmo_q     <= r_tmo_s;

            if (w_wr_ctrl) begin
                r_pwm_en      <= wdata[1];
                r_auto_reload <= wdata[2];
                r_irq_en      <= wdata[3];
            end

            if (w_wr_load) begin
                r_load <= (wdata == 32'd0) ? 32'd1 : wdata;
            end

            if (w_wr_pwm) begin
                r_period_sh <= wdata[15:0];
                r_duty_sh   <= wdata[31:16];
            end

            if (w_wr_pwm & ~r_pwm_en) begin
                r_period <= wdata[15:0];
                r_duty   <= wdata[31:16];
            end else if (w_pwm_commit) begin
                r_period <= r_period_sh;
                r_duty   <= r_duty_sh;
            end

            if (w_edge) begin
                r_timeout <= 1'b1;
            end else if (w_wr_status & wdata[0]) begin
                r_timeout <= 1'b0;
            end

            if (w_wr_count) begin
                r_count <= '0;
            end else if (w_edge) begin
                r_count <= r_count + 16'd1;
            end

            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_edge & ~r_auto_reload) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign ack             = r_ack;
    assign rdata           = r_rdata;
    assign timer_en        = r_start_pls | w_reload;
    assign pwm_en          = r_pwm_en;
    assign load_tmr0       = r_load;
    assign load_pwm0       = r_period;
    assign duty_cycle_pwm0 = r_duty;
    assign irq             = r_irq_en & r_timeout;

endmodule
`default_nettype wire
